// File: rtl/chan_scan_mux_pkg.sv
// Shared mode encodings and auto-scan state type for the channel scan mux.
package chan_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/chan_scan_mux_dwell_counter.sv
// Dwell counter: 1-cycle registered count, clear has priority over increment.
// Terminal is combinational (count == dwell); no backpressure of its own.
module dwell_counter #(
    parameter int DW_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic [DW_W-1:0] dwell,
    output logic            terminal
);

    logic [DW_W-1:0] count_q;
    logic [DW_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + DW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == dwell);

endmodule

// File: rtl/chan_scan_mux.sv
// N-way channel selector, manual or auto-scan; sample lands on out_* 1 cycle after issue.
// Output register holds while out_valid & !out_ready; issue only when the slot frees.
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter int NCH   = 13,
    parameter int W     = 1,
    parameter int SEL_W = 4,
    parameter int DW_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] ch_data,
    input  logic             mode,
    input  logic             en,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             sel_load,
    input  logic [DW_W-1:0]  dwell,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_err
);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic             slot_free;
    logic             auto_on;
    logic             sel_ok;
    logic             issue;
    logic             advance;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_term;
    logic [W-1:0]     sel_dat;
    logic [SEL_W-1:0] next_ch;

    assign slot_free = !out_valid_q || out_ready;
    assign auto_on   = en && (mode == MODE_AUTO);
    // Extra bit keeps the compare correct when 2**SEL_W == NCH.
    assign sel_ok    = ({1'b0, sel_in} < (SEL_W+1)'(NCH));
    assign next_ch   = (cur_ch_q == SEL_W'(NCH-1)) ? '0 : cur_ch_q + SEL_W'(1);

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cur_ch_q == SEL_W'(k)) begin
                sel_dat = ch_data[k*W +: W];
            end
        end
    end

    dwell_counter #(
        .DW_W (DW_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .dwell    (dwell),
        .terminal (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        issue    = 1'b0;
        advance  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;

        if (!auto_on) begin
            // Leaving auto (en low or manual mode) always restarts the dwell.
            state_d = IDLE;
            cnt_clr = 1'b1;
            issue   = en && (mode == MODE_MANUAL) && slot_free;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    cnt_clr = 1'b1;
                end
                COUNT: begin
                    if (cnt_term) begin
                        if (slot_free) begin
                            issue   = 1'b1;
                            advance = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                WAIT: begin
                    if (slot_free) begin
                        issue   = 1'b1;
                        advance = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = COUNT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end

        if (advance) begin
            cur_ch_d = next_ch;
        end
        if (sel_load && sel_ok) begin
            cur_ch_d = sel_in;
            cnt_clr  = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_load && !sel_ok;
        if (issue) begin
            out_data_d  = sel_dat;
            out_ch_d    = cur_ch_q;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux with a queue-based scoreboard and negedge monitor.
module tb_chan_scan_mux;

    localparam int NCH   = 13;
    localparam int W     = 1;
    localparam int SEL_W = 4;
    localparam int DW_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH*W-1:0] ch_data;
    logic             mode;
    logic             en;
    logic [SEL_W-1:0] sel_in;
    logic             sel_load;
    logic [DW_W-1:0]  dwell;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;

    typedef struct {
        int ch;
        int data;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_pop = 0;
    logic [NCH*W-1:0] pat;

    chan_scan_mux #(
        .NCH   (NCH),
        .W     (W),
        .SEL_W (SEL_W),
        .DW_W  (DW_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_data   (ch_data),
        .mode      (mode),
        .en        (en),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .dwell     (dwell),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int gap);
        exp_t e;
        e.ch   = ch;
        e.data = int'(pat[ch]);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got ch=%0d data=%0d expected none", out_ch, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_ch", int'(out_ch), e.ch);
                check("out_data", int'(out_data), e.data);
                if (e.gap != 0) check("sample_gap", cyc - last_pop, e.gap);
            end
            last_pop = cyc;
        end
    end

    initial begin
        pat       = 13'h0AD5;
        ch_data   = pat;
        mode      = 1'b0;
        en        = 1'b0;
        sel_in    = '0;
        sel_load  = 1'b0;
        dwell     = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;

        // Reset values appear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_ch", int'(out_ch), 0);
        check("rst_sel_err", int'(sel_err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Manual: load channel 7, then one sample.
        sel_in = 4'd7; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        push(7, 0);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check("man_valid_drop", int'(out_valid), 0);

        // Manual full throughput on channel 3.
        sel_in = 4'd3; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        push(3, 0); push(3, 1); push(3, 1);
        en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        drain(10);

        // Out-of-range selects: one-cycle error pulse, channel unchanged.
        for (int b = 13; b <= 15; b += 2) begin
            sel_in = SEL_W'(b); sel_load = 1'b1;
            tick();
            sel_load = 1'b0;
            check("sel_err_pulse", int'(sel_err), 1);
            tick();
            check("sel_err_clear", int'(sel_err), 0);
        end
        push(3, 0);
        en = 1'b1;
        tick();
        en = 1'b0;
        drain(10);

        // Auto scan, dwell=2: one sample every 3 cycles, 0..12 then wrap to 0.
        sel_in = 4'd0; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        for (int k = 0; k <= NCH; k++) push(k % NCH, (k == 0) ? 0 : 3);
        dwell = 16'd2; mode = 1'b1; en = 1'b1;
        drain(80);
        en = 1'b0;
        tick(); tick();

        // en dropped mid-dwell: scan resumes at channel 1 with a fresh count.
        en = 1'b1;
        tick(); tick();
        en = 1'b0;
        tick(); tick();
        push(1, 0);
        en = 1'b1;
        tick(); tick(); tick();
        check("resume_no_early", int'(out_valid), 0);
        tick();
        check("resume_valid", int'(out_valid), 1);
        en = 1'b0;
        tick(); tick();

        // Backpressure, dwell=0: output frozen on channel 2, no skip on release.
        dwell = 16'd0; out_ready = 1'b0; en = 1'b1;
        push(2, 0); push(3, 1); push(4, 1); push(5, 1);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_ch", int'(out_ch), 2);
            check("bp_data", int'(out_data), int'(pat[2]));
            tick();
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        tick(); tick();
        check("bp_left", exp_q.size(), 0);

        // Async reset while a sample is held: cleared at once, not retained.
        mode = 1'b0; out_ready = 1'b0;
        sel_in = 4'd7; sel_load = 1'b1;
        tick();
        sel_load = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        check("held_valid", int'(out_valid), 1);
        check("held_data", int'(out_data), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_ch", int'(out_ch), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_no_retain", int'(out_valid), 0);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
